// File: rtl/elastic_memory_arbiter.sv
// Round-robin arbiter that shares one single-ported synchronous data memory
// between NUM_PORTS elastic load/store requesters. Each port owns a single
// registered read-response slot. A load may only issue when that slot is
// free and no read for the port is in flight. Stores need no slot.
module elastic_memory_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 16,
    parameter int PORT_BIT_LENGTH = $clog2(NUM_PORTS)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_PORTS-1:0]                      req_valid,
    output logic [NUM_PORTS-1:0]                      req_stop,
    input  logic [NUM_PORTS-1:0]                      req_write,
    input  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0]   req_address,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]      req_write_data,
    output logic [NUM_PORTS-1:0]                      resp_valid,
    input  logic [NUM_PORTS-1:0]                      resp_stop,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]      resp_data,
    output logic [ADDRESS_WIDTH-1:0]                  memory_read_address,
    output logic [ADDRESS_WIDTH-1:0]                  memory_write_address,
    output logic                                      memory_write,
    output logic [DATA_WIDTH-1:0]                     memory_write_data,
    input  logic [DATA_WIDTH-1:0]                     memory_read_data,
    output logic                                      grant_valid,
    output logic [PORT_BIT_LENGTH-1:0]                grant_index
);

    logic [PORT_BIT_LENGTH-1:0] rr_ptr;
    logic                       rd_inflight;
    logic [PORT_BIT_LENGTH-1:0] rd_port;
    logic [ADDRESS_WIDTH-1:0]   last_read_address;

    logic [NUM_PORTS-1:0]       pending;
    logic [NUM_PORTS-1:0]       eligible;
    logic                       grant_any;
    logic [PORT_BIT_LENGTH-1:0] grant_port;
    logic                       load_grant;
    logic                       store_grant;

    // A port is blocked from loading while its slot is full or its read is in flight.
    always_comb begin
        pending  = '0;
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pending[i]  = resp_valid[i] | (rd_inflight & (rd_port == PORT_BIT_LENGTH'(i)));
            eligible[i] = req_valid[i] & (req_write[i] | ~pending[i]);
        end
    end

    // Scan from rr_ptr upward with wrap; the first eligible port wins.
    always_comb begin
        int                         sum;
        logic [PORT_BIT_LENGTH-1:0] idx;
        grant_any  = 1'b0;
        grant_port = '0;
        sum        = 0;
        idx        = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_PORTS) begin
                sum = sum - NUM_PORTS;
            end
            idx = PORT_BIT_LENGTH'(sum);
            if (!grant_any && eligible[idx]) begin
                grant_any  = 1'b1;
                grant_port = idx;
            end
        end
    end

    // Handshake and memory drive derived from the single winner.
    always_comb begin
        load_grant           = grant_any & ~req_write[grant_port];
        store_grant          = grant_any & req_write[grant_port];
        grant_valid          = grant_any;
        grant_index          = grant_port;
        req_stop             = '1;
        if (grant_any) begin
            req_stop[grant_port] = 1'b0;
        end
        memory_write         = store_grant;
        memory_write_address = store_grant ? req_address[grant_port] : '0;
        memory_write_data    = store_grant ? req_write_data[grant_port] : '0;
        memory_read_address  = load_grant ? req_address[grant_port] : last_read_address;
    end

    // Arbitration pointer and read-tracking control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr            <= '0;
            rd_inflight       <= 1'b0;
            rd_port           <= '0;
            last_read_address <= '0;
        end else begin
            if (grant_any) begin
                rr_ptr <= (int'(grant_port) == NUM_PORTS - 1) ? '0 : grant_port + 1'b1;
            end
            rd_inflight <= load_grant;
            if (load_grant) begin
                rd_port           <= grant_port;
                last_read_address <= req_address[grant_port];
            end
        end
    end

    // Response slots: drain on handshake, capture memory data one cycle after issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (resp_valid[i] && !resp_stop[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
            if (rd_inflight) begin
                resp_valid[rd_port] <= 1'b1;
                resp_data[rd_port]  <= memory_read_data;
            end
        end
    end

endmodule
